// File: rtl/arb8_sched.sv
// arb8_sched: registered 8-requester arbiter with grant hold limit.
// Default selection is fixed priority (index 7 highest); define ARB8_RR_EN
// for round-robin selection starting at the slot after the last grant.
module arb8_sched #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CW       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       en,
  output logic [7:0] gnt,
  output logic [2:0] gnt_id,
  output logic       busy,
  output logic       idle
);

  localparam int unsigned NREQ = 8;

  typedef enum logic {IDLE, OWN} state_t;

  state_t          r_state, w_state_nxt;
  logic [7:0]      r_gnt, w_gnt_nxt;
  logic [2:0]      r_gnt_id, w_gnt_id_nxt;
  logic [CW-1:0]   r_hold_cnt, w_hold_nxt;
  logic            r_busy;
  logic [7:0]      w_cand;
  logic [7:0]      w_others;
  logic [2:0]      w_win;
  logic            w_new;
  logic            w_limit;

`ifdef ARB8_RR_EN
  logic [2:0]      r_rr_ptr, w_rr_ptr_nxt;

  // First set bit scanning upward from ptr, wrapping 7 -> 0.
  function automatic logic [2:0] pick(input logic [7:0] v, input logic [2:0] ptr);
    logic [2:0] idx;
    logic       found;
    idx   = 3'd0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && v[3'(ptr + 3'(k))]) begin
        idx   = 3'(ptr + 3'(k));
        found = 1'b1;
      end
    end
    return idx;
  endfunction
`else
  // Highest set index wins.
  function automatic logic [2:0] pick(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < NREQ; i++) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction
`endif

  assign w_others = req & ~r_gnt;
  assign w_limit  = (r_hold_cnt == CW'(MAX_HOLD - 1));

  // Next-state, grant selection and hold counter update.
  always_comb begin
    w_state_nxt  = r_state;
    w_gnt_nxt    = r_gnt;
    w_gnt_id_nxt = r_gnt_id;
    w_hold_nxt   = r_hold_cnt;
    w_cand       = 8'h00;
    w_new        = 1'b0;
    w_win        = 3'd0;

    case (r_state)
      IDLE: begin
        if (en && (req != 8'h00)) begin
          w_cand = req;
          w_new  = 1'b1;
        end
      end
      OWN: begin
        if (req[r_gnt_id]) begin
          if (en && w_limit && (w_others != 8'h00)) begin
            w_cand = w_others;
            w_new  = 1'b1;
          end else if (!w_limit) begin
            w_hold_nxt = r_hold_cnt + CW'(1);
          end
        end else if (en && (w_others != 8'h00)) begin
          w_cand = w_others;
          w_new  = 1'b1;
        end else begin
          w_state_nxt  = IDLE;
          w_gnt_nxt    = 8'h00;
          w_gnt_id_nxt = 3'd0;
          w_hold_nxt   = '0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

`ifdef ARB8_RR_EN
    w_win        = pick(w_cand, r_rr_ptr);
    w_rr_ptr_nxt = r_rr_ptr;
    if (w_new) w_rr_ptr_nxt = 3'(w_win + 3'd1);
`else
    w_win = pick(w_cand);
`endif

    if (w_new) begin
      w_state_nxt  = OWN;
      w_gnt_id_nxt = w_win;
      w_gnt_nxt    = 8'b1 << w_win;
      w_hold_nxt   = '0;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_gnt      <= 8'h00;
      r_gnt_id   <= 3'd0;
      r_hold_cnt <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_gnt      <= w_gnt_nxt;
      r_gnt_id   <= w_gnt_id_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_busy     <= (w_gnt_nxt != 8'h00);
    end
  end

`ifdef ARB8_RR_EN
  // Round-robin pointer: slot after the most recent grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_rr_ptr <= 3'd0;
    else     r_rr_ptr <= w_rr_ptr_nxt;
  end
`endif

  assign gnt    = r_gnt;
  assign gnt_id = r_gnt_id;
  assign busy   = r_busy;
  assign idle   = (req == 8'h00);

endmodule
